pe_mem_arbiter: RTL

Shares one data-memory port between the two processing elements of the dual-PE core, replacing the per-PE private data memories. Each PE issues load/store requests over a valid/ready interface; the block arbitrates round-robin, sequences one access at a time through the memory port, waits the memory's fixed read latency, and returns a one-cycle response to the owning PE. It sits between each PE's ALU/result-mux datapath and a single shared data memory.

---
 rtl/pe_arb_pkg.sv | 24 ++
 rtl/rr_arbiter_2.sv | 28 ++
 rtl/pe_mem_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pe_arb_pkg.sv
// ============================================================================
// pe_arb_pkg : shared types and constants for the dual-PE memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package pe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic PE1 = 1'b0;
    localparam logic PE2 = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;
    localparam int CNT_W       = 3;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
// rr_arbiter_2 : two-way round-robin grant, purely combinational
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_2
    import pe_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            // Tie goes to whichever PE was not served most recently.
            2'b11:   o_grant = (i_last_grant == PE2) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pe_mem_arbiter.sv
// ============================================================================
// pe_mem_arbiter : shares one data-memory port between two PEs, one access
//                  at a time, round-robin, fixed read latency
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_mem_arbiter
    import pe_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    input  logic              req2_valid,
    input  logic              req2_we,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [DATA_W-1:0] req2_wdata,
    output logic              req2_ready,
    output logic              resp2_valid,
    output logic [DATA_W-1:0] resp2_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          w_grant;
    logic                w_accept;
    logic                w_done;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_resp1_valid;
    logic                r_resp2_valid;
    logic [DATA_W-1:0]   r_resp1_rdata;
    logic [DATA_W-1:0]   r_resp2_rdata;

    rr_arbiter_2 u_arb (
        .i_req        ({req2_valid, req1_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_accept = (r_state == IDLE) && (w_grant != 2'b00);
    assign w_done   = (r_state == WAIT) && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (w_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Ready is gated by rst so nothing is offered while reset is held.
    always_comb begin
        req1_ready = 1'b0;
        req2_ready = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        if ((r_state == IDLE) && !rst) begin
            req1_ready = w_grant[0];
            req2_ready = w_grant[1];
        end
        if (r_state == ISSUE) begin
            mem_en = 1'b1;
            mem_we = r_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner       <= PE1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_last_grant  <= PE2;
            r_cnt         <= '0;
            r_resp1_valid <= 1'b0;
            r_resp2_valid <= 1'b0;
            r_resp1_rdata <= '0;
            r_resp2_rdata <= '0;
        end else begin
            r_resp1_valid <= 1'b0;
            r_resp2_valid <= 1'b0;
            if (w_accept) begin
                r_owner      <= w_grant[1] ? PE2 : PE1;
                r_last_grant <= w_grant[1] ? PE2 : PE1;
                r_we         <= w_grant[1] ? req2_we    : req1_we;
                r_addr       <= w_grant[1] ? req2_addr  : req1_addr;
                r_wdata      <= w_grant[1] ? req2_wdata : req1_wdata;
            end
            if (r_state == ISSUE) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_done) begin
                if (r_owner == PE1) begin
                    r_resp1_valid <= 1'b1;
                    r_resp1_rdata <= r_we ? '0 : mem_rdata;
                end else begin
                    r_resp2_valid <= 1'b1;
                    r_resp2_rdata <= r_we ? '0 : mem_rdata;
                end
            end
        end
    end

    assign resp1_valid = r_resp1_valid;
    assign resp2_valid = r_resp2_valid;
    assign resp1_rdata = r_resp1_rdata;
    assign resp2_rdata = r_resp2_rdata;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

endmodule

`default_nettype wire
